// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
//
// Interrupt controller feeding the processor core's INT input. External
// request lines are edge-detected and latched as pending. A per-source enable
// mask filters them, and the lowest-numbered enabled pending source is
// selected. The controller then raises INT with that source's handler vector
// and runs a non-nesting request / acknowledge / end-of-interrupt handshake.
//
// Ports
//   clk      in   1        system clock, all state updates on rising edge
//   rst      in   1        synchronous reset, active-high
//   irq      in   N        external request lines (rising edge = request)
//   mask_wr  in   1        load mask register from mask_in this cycle
//   mask_in  in   N        new enable mask (1 = source enabled)
//   int_ack  in   1        core accepted the interrupt (honoured in REQ)
//   eoi      in   1        core finished the handler (honoured in SERVICE)
//   INT      out  1        interrupt request to core
//   vec      out  32       handler address of the selected source
//   irq_id   out  clog2(N) index of the selected source
//   pending  out  N        current pending register
//   busy     out  1        high while a handler is in service
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module int_ctrl #(
  parameter int          N          = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'd16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         irq,
  input  logic                 mask_wr,
  input  logic [N-1:0]         mask_in,
  input  logic                 int_ack,
  input  logic                 eoi,
  output logic                 INT,
  output logic [31:0]          vec,
  output logic [$clog2(N)-1:0] irq_id,
  output logic [N-1:0]         pending,
  output logic                 busy
);

  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             int_q, int_d;
  logic             busy_q, busy_d;
  logic [31:0]      vec_q, vec_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [N-1:0]     irq_q;

  logic [N-1:0]     rise;
  logic [N-1:0]     eligible;
  logic [IDW-1:0]   sel;
  logic [N-1:0]     clr;
  logic             ack_take;

  // ---- request capture: edge detect and eligibility ----
  assign rise     = irq & ~irq_q;
  assign eligible = pending_q & mask_q;

  // Fixed priority: scan from the top so the lowest set index is the last
  // one written and therefore wins.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel = i[IDW-1:0];
      end
    end
  end

  // An acknowledge only counts while a request is outstanding.
  assign ack_take = (state_q == S_REQ) && int_ack;
  assign clr      = ack_take ? ({{(N-1){1'b0}}, 1'b1} << id_q) : '0;

  // Set wins over clear: an edge arriving on the very cycle its bit is being
  // acknowledged must not be lost, so the rise term is OR-ed in last.
  assign pending_d = (pending_q & ~clr) | rise;

  assign mask_d = mask_wr ? mask_in : mask_q;

  // ---- handshake FSM: next state and registered outputs ----
  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    busy_d  = busy_q;
    vec_d   = vec_q;
    id_d    = id_q;

    unique case (state_q)
      S_IDLE: begin
        int_d  = 1'b0;
        busy_d = 1'b0;
        if (|eligible) begin
          id_d    = sel;
          // 32-bit wrap-around on the vector is intentional.
          vec_d   = VEC_BASE + VEC_STRIDE * {{(32-IDW){1'b0}}, sel};
          int_d   = 1'b1;
          state_d = S_REQ;
        end
      end

      // vec/irq_id stay frozen here regardless of mask or pending changes;
      // eoi is ignored, so int_ack+eoi together behaves as int_ack alone.
      S_REQ: begin
        int_d  = 1'b1;
        busy_d = 1'b0;
        if (int_ack) begin
          int_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SERVICE;
        end
      end

      // No nesting: new edges only accumulate in pending until eoi.
      S_SERVICE: begin
        int_d  = 1'b0;
        busy_d = 1'b1;
        if (eoi) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        int_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---- state registers ----
  // irq_q resets to zero, so a line already high when reset releases is seen
  // as one fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      int_q     <= 1'b0;
      busy_q    <= 1'b0;
      vec_q     <= '0;
      id_q      <= '0;
      pending_q <= '0;
      mask_q    <= '1;
      irq_q     <= '0;
    end else begin
      state_q   <= state_d;
      int_q     <= int_d;
      busy_q    <= busy_d;
      vec_q     <= vec_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= irq;
    end
  end

  assign INT     = int_q;
  assign busy    = busy_q;
  assign vec     = vec_q;
  assign irq_id  = id_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
//
// Scoreboard bench for int_ctrl (N=4). Each time stimulus creates a request
// the expected (id, vector) pair is pushed; it is popped and compared when the
// DUT raises INT. Control outputs are checked directly at key points.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam int          N          = 4;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE = 32'd16;

  logic         clk;
  logic         rst;
  logic [N-1:0] irq;
  logic         mask_wr;
  logic [N-1:0] mask_in;
  logic         int_ack;
  logic         eoi;
  logic         INT;
  logic [31:0]  vec;
  logic [1:0]   irq_id;
  logic [N-1:0] pending;
  logic         busy;

  typedef struct {
    int          id;
    logic [31:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_err;

  int_ctrl #(
    .N          (N),
    .VEC_BASE   (VEC_BASE),
    .VEC_STRIDE (VEC_STRIDE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .irq     (irq),
    .mask_wr (mask_wr),
    .mask_in (mask_in),
    .int_ack (int_ack),
    .eoi     (eoi),
    .INT     (INT),
    .vec     (vec),
    .irq_id  (irq_id),
    .pending (pending),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is somehow bypassed.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id  = id;
    e.vec = VEC_BASE + VEC_STRIDE * id;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for INT, then pops the oldest expectation and compares.
  // exp_lat < 0 skips the latency check.
  task automatic expect_int(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    while (!INT && n < 20) begin
      step();
      n++;
    end
    if (!INT) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_id"}, {30'd0, irq_id}, e.id);
      chk({tag, "_vec"}, vec, e.vec);
      if (exp_lat >= 0) chk({tag, "_lat"}, n, exp_lat);
    end
  endtask

  task automatic do_ack(input string tag);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk({tag, "_ack_int"}, {31'd0, INT}, 32'd0);
    chk({tag, "_ack_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic do_eoi(input string tag);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk({tag, "_eoi_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_irq(input logic [N-1:0] v);
    irq = v;
    step();
    irq = '0;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    irq     = '0;
    mask_wr = 1'b0;
    mask_in = '0;
    int_ack = 1'b0;
    eoi     = 1'b0;

    // Reset state.
    repeat (3) step();
    chk("rst_int", {31'd0, INT}, 32'd0);
    chk("rst_vec", vec, 32'd0);
    chk("rst_id", {30'd0, irq_id}, 32'd0);
    chk("rst_pending", {28'd0, pending}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Release with irq[2] already high: counts as one edge.
    rst = 1'b0;
    irq = 4'b0100;
    step();
    chk("rel_pending", {28'd0, pending}, 32'h4);
    chk("rel_int_low", {31'd0, INT}, 32'd0);
    push_exp(2);
    expect_int("rel", 1);
    do_ack("rel");
    chk("rel_pending_clr", {28'd0, pending}, 32'd0);
    do_eoi("rel");
    irq = '0;
    step();

    // Single request on source 1.
    pulse_irq(4'b0010);
    chk("single_pending", {28'd0, pending}, 32'h2);
    push_exp(1);
    expect_int("single", 1);
    do_ack("single");
    chk("single_pending_clr", {28'd0, pending}, 32'd0);
    do_eoi("single");
    step();
    chk("single_idle_int", {31'd0, INT}, 32'd0);

    // Priority: 1 and 3 together, 1 first, 3 after one idle cycle.
    pulse_irq(4'b1010);
    push_exp(1);
    push_exp(3);
    expect_int("prio1", 1);
    do_ack("prio1");
    chk("prio_pending", {28'd0, pending}, 32'h8);
    do_eoi("prio1");
    chk("prio_gap_int", {31'd0, INT}, 32'd0);
    expect_int("prio3", 1);
    do_ack("prio3");
    do_eoi("prio3");

    // Masking: source 0 disabled, stays pending, fires once enabled.
    mask_wr = 1'b1;
    mask_in = 4'b1110;
    step();
    mask_wr = 1'b0;
    pulse_irq(4'b0001);
    repeat (3) step();
    chk("mask_int_low", {31'd0, INT}, 32'd0);
    chk("mask_pending", {28'd0, pending}, 32'h1);
    mask_wr = 1'b1;
    mask_in = 4'b1111;
    step();
    mask_wr = 1'b0;
    push_exp(0);
    expect_int("unmask", 1);
    do_ack("unmask");
    do_eoi("unmask");

    // Set-wins collision on source 2, plus frozen vector while in REQ.
    pulse_irq(4'b0100);
    push_exp(2);
    expect_int("sw", 1);
    pulse_irq(4'b0001);
    chk("sw_frozen_id", {30'd0, irq_id}, 32'd2);
    chk("sw_frozen_vec", vec, 32'h120);
    chk("sw_frozen_int", {31'd0, INT}, 32'd1);
    irq     = 4'b0100;
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    irq     = '0;
    chk("sw_pending", {28'd0, pending}, 32'h5);
    chk("sw_busy", {31'd0, busy}, 32'd1);
    chk("sw_int", {31'd0, INT}, 32'd0);
    do_eoi("sw");
    push_exp(0);
    push_exp(2);
    expect_int("sw0", 1);
    do_ack("sw0");
    do_eoi("sw0");
    expect_int("sw2", 1);
    do_ack("sw2");
    do_eoi("sw2");

    // Reset mid-handshake while in SERVICE with source 3 pending.
    pulse_irq(4'b0001);
    push_exp(0);
    expect_int("mid", 1);
    do_ack("mid");
    pulse_irq(4'b1000);
    chk("mid_pending", {28'd0, pending}, 32'h8);
    mask_wr = 1'b1;
    mask_in = 4'b0000;
    step();
    mask_wr = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_int", {31'd0, INT}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_pending", {28'd0, pending}, 32'd0);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    chk("mid_eoi_ign_busy", {31'd0, busy}, 32'd0);
    chk("mid_eoi_ign_int", {31'd0, INT}, 32'd0);
    // Mask must be back to all ones after reset.
    pulse_irq(4'b1000);
    push_exp(3);
    expect_int("postrst", 1);
    do_ack("postrst");
    do_eoi("postrst");

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
